// File: rtl/omem_potential_store_if.sv
// Valid/ready packet channels between the sum-PE network and the output-memory node.
// The inbound channel carries writes and read requests; the outbound channel carries replies and broadcasts.
interface omem_potential_store_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_dest;
    logic [3:0]  in_opcode;
    logic [24:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_dest;
    logic [3:0]  out_opcode;
    logic [24:0] out_data;

    modport master (
        output in_valid, in_dest, in_opcode, in_data, out_ready,
        input  in_ready, out_valid, out_dest, out_opcode, out_data
    );

    modport slave (
        input  in_valid, in_dest, in_opcode, in_data, out_ready,
        output in_ready, out_valid, out_dest, out_opcode, out_data
    );
endinterface

// File: rtl/omem_potential_store.sv
// Output-memory node: stores per-neuron residual potentials and spikes, answers previous-potential
// requests from the sum PEs, and broadcasts the timestep-done packet at each timestep boundary.
module omem_potential_store #(
    parameter int NUM_PE         = 3,
    parameter int NEURONS_PER_PE = 147,
    parameter int NUM_TIMESTEPS  = 2,
    parameter int POT_WIDTH      = 13,
    parameter int OMEM_ID        = 12,
    parameter int SPE_ADDR_BASE  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    omem_potential_store_if.slave bus,
    input  logic [8:0]           spk_rd_addr,
    output logic                 spk_rd_data,
    output logic [1:0]           timestep,
    output logic                 all_done,
    output logic                 err
);
    localparam int TOTAL  = NUM_PE * NEURONS_PER_PE;
    localparam int ADDR_W = 9;
    localparam int PTR_W  = $clog2(NEURONS_PER_PE + 1);
    localparam int CNT_W  = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, RD, RESP, BCAST, DONE} state_t;

    state_t              state;
    logic [PTR_W-1:0]    ptr [NUM_PE];
    logic [CNT_W-1:0]    wr_cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [3:0]          rd_dest;
    logic [1:0]          bc_idx;
    logic [POT_WIDTH-1:0] pot_mem [TOTAL];
    logic                spk_mem [TOTAL];

    logic [2:0]          pe_id;
    logic                req;
    logic [PTR_W-1:0]    ptr_sel;
    logic [ADDR_W-1:0]   base_sel;
    logic [3:0]          dest_sel;
    logic [ADDR_W-1:0]   acc_addr;
    logic                pkt_bad;
    logic                wr_en;
    logic                unused_in_data;

    assign pe_id          = bus.in_opcode[3:1];
    assign req            = bus.in_opcode[0];
    assign unused_in_data = &{1'b0, bus.in_data[24:POT_WIDTH+1]};

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ptr_sel  = '0;
        base_sel = '0;
        dest_sel = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            if (pe_id == 3'(p)) begin
                ptr_sel  = ptr[p];
                base_sel = ADDR_W'(p * NEURONS_PER_PE);
                dest_sel = 4'(SPE_ADDR_BASE + p);
            end
        end
    end

    assign acc_addr = base_sel + ADDR_W'(ptr_sel);
    assign pkt_bad  = (bus.in_dest != 4'(OMEM_ID)) || (pe_id >= 3'(NUM_PE)) ||
                      (ptr_sel == PTR_W'(NEURONS_PER_PE));
    assign wr_en    = (state == IDLE) && bus.in_valid && !pkt_bad && !req;

    // NOTE: RAM arrays carry no reset so they can map onto block memory.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pot_mem[acc_addr] <= bus.in_data[POT_WIDTH:1];
            spk_mem[acc_addr] <= bus.in_data[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_rd_data <= 1'b0;
        end else begin
            spk_rd_data <= (spk_rd_addr < ADDR_W'(TOTAL)) ? spk_mem[spk_rd_addr] : 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_dest   <= '0;
            bus.out_opcode <= '0;
            bus.out_data   <= '0;
            for (int p = 0; p < NUM_PE; p++) ptr[p] <= '0;
            wr_cnt         <= '0;
            rd_addr        <= '0;
            rd_dest        <= '0;
            bc_idx         <= '0;
            timestep       <= 2'd1;
            all_done       <= 1'b0;
            err            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (pkt_bad) begin
                            err <= 1'b1;
                        end else if (req) begin
                            rd_addr      <= acc_addr;
                            rd_dest      <= dest_sel;
                            bus.in_ready <= 1'b0;
                            state        <= RD;
                        end else begin
                            for (int p = 0; p < NUM_PE; p++) begin
                                if (pe_id == 3'(p)) ptr[p] <= ptr[p] + 1'b1;
                            end
                            wr_cnt <= wr_cnt + 1'b1;
                            if (wr_cnt == CNT_W'(TOTAL - 1)) begin
                                bus.in_ready <= 1'b0;
                                if (timestep == 2'(NUM_TIMESTEPS)) begin
                                    all_done <= 1'b1;
                                    state    <= DONE;
                                end else begin
                                    bus.out_valid  <= 1'b1;
                                    bus.out_dest   <= 4'(SPE_ADDR_BASE);
                                    bus.out_opcode <= 4'd15;
                                    bus.out_data   <= '0;
                                    bc_idx         <= '0;
                                    state          <= BCAST;
                                end
                            end
                        end
                    end
                end
                RD: begin
                    // No potential survives into timestep 1, so the RAM value is masked.
                    bus.out_valid  <= 1'b1;
                    bus.out_dest   <= rd_dest;
                    bus.out_opcode <= 4'd2;
                    bus.out_data   <= (timestep == 2'd1) ? '0 : 25'(pot_mem[rd_addr]);
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                BCAST: begin
                    if (bus.out_ready) begin
                        if (bc_idx == 2'(NUM_PE - 1)) begin
                            bus.out_valid <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            timestep      <= timestep + 1'b1;
                            for (int p = 0; p < NUM_PE; p++) ptr[p] <= '0;
                            wr_cnt        <= '0;
                            state         <= IDLE;
                        end else begin
                            bc_idx       <= bc_idx + 1'b1;
                            bus.out_dest <= bus.out_dest + 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                    all_done      <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
